interrupt_controller: RTL and testbench

// Collects NSRC asynchronous peripheral interrupt lines and synchronizes, latches, masks and prioritizes them.

---
 rtl/leg_intc_pkg.sv | 19 +
 rtl/intc_sync_edge.sv | 30 +++
 rtl/interrupt_controller.sv | 165 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leg_intc_pkg.sv
// Shared definitions for the interrupt controller: register map and the
// per-line request state encoding.
package leg_intc_pkg;

    localparam logic [2:0] INTC_MASK      = 3'd0;
    localparam logic [2:0] INTC_FIQSEL    = 3'd1;
    localparam logic [2:0] INTC_EDGE      = 3'd2;
    localparam logic [2:0] INTC_PENDING   = 3'd3;
    localparam logic [2:0] INTC_IRQ_CLAIM = 3'd4;
    localparam logic [2:0] INTC_FIQ_CLAIM = 3'd5;
    localparam logic [2:0] INTC_EOI       = 3'd6;

    typedef enum logic [1:0] {
        INTC_IDLE,
        INTC_REQ,
        INTC_SERVICE
    } intc_state_t;

endpackage

// File: rtl/intc_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line, plus a history
// flop so a rising edge can be detected on the synchronized level.
module intc_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic src,
    output logic level,
    output logic rise
);

    // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3 (history)
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], src};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronizes, latches, masks and prioritizes NSRC
// lines onto independent IRQ and FIQ request/claim/EOI state machines.
module interrupt_controller
    import leg_intc_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] IntSrc,
    input  logic            CfgWE,
    input  logic [2:0]      CfgAddr,
    input  logic [31:0]     CfgWData,
    output logic [31:0]     CfgRData,
    input  logic            IRQAssert,
    input  logic            FIQAssert,
    output logic            IRQ,
    output logic            FIQ,
    output logic [IDW-1:0]  IRQId,
    output logic [IDW-1:0]  FIQId
);

    // Lowest set index wins; callers only use the result when v != 0.
    function automatic logic [IDW-1:0] lowest_idx(input logic [NSRC-1:0] v);
        lowest_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDW'(i);
        end
    endfunction

    logic [NSRC-1:0] src_level;
    logic [NSRC-1:0] src_rise;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        intc_sync_edge u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .src     (IntSrc[g]),
            .level   (src_level[g]),
            .rise    (src_rise[g])
        );
    end

    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] fiqsel_q, fiqsel_d;
    logic [NSRC-1:0] edge_sel_q, edge_sel_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic [IDW-1:0]  fiq_id_q, fiq_id_d;
    intc_state_t     irq_state_q, irq_state_d;
    intc_state_t     fiq_state_q, fiq_state_d;

    logic [NSRC-1:0] irq_cand, fiq_cand;
    logic [NSRC-1:0] irq_clr, fiq_clr;
    logic            irq_take, fiq_take;
    logic            eoi_wr;
    logic            unused_wdata;

    assign unused_wdata = ^CfgWData;

    // Candidates come from registered state, so a config write landing on the
    // same edge as an ack does not affect what that ack claims.
    assign irq_cand = pend_q & mask_q & ~fiqsel_q;
    assign fiq_cand = pend_q & mask_q &  fiqsel_q;
    assign eoi_wr   = CfgWE && (CfgAddr == INTC_EOI);

    always_comb begin
        irq_state_d = irq_state_q;
        irq_id_d    = irq_id_q;
        irq_take    = 1'b0;
        case (irq_state_q)
            INTC_IDLE:    if (irq_cand != '0) irq_state_d = INTC_REQ;
            INTC_REQ: begin
                if (irq_cand == '0) begin
                    irq_state_d = INTC_IDLE;
                end else if (IRQAssert) begin
                    irq_state_d = INTC_SERVICE;
                    irq_id_d    = lowest_idx(irq_cand);
                    irq_take    = 1'b1;
                end
            end
            INTC_SERVICE: if (eoi_wr && CfgWData[0]) irq_state_d = INTC_IDLE;
            default:      irq_state_d = INTC_IDLE;
        endcase
    end

    always_comb begin
        fiq_state_d = fiq_state_q;
        fiq_id_d    = fiq_id_q;
        fiq_take    = 1'b0;
        case (fiq_state_q)
            INTC_IDLE:    if (fiq_cand != '0) fiq_state_d = INTC_REQ;
            INTC_REQ: begin
                if (fiq_cand == '0) begin
                    fiq_state_d = INTC_IDLE;
                end else if (FIQAssert) begin
                    fiq_state_d = INTC_SERVICE;
                    fiq_id_d    = lowest_idx(fiq_cand);
                    fiq_take    = 1'b1;
                end
            end
            INTC_SERVICE: if (eoi_wr && CfgWData[1]) fiq_state_d = INTC_IDLE;
            default:      fiq_state_d = INTC_IDLE;
        endcase
    end

    // One-hot of the winner (lowest set bit), restricted to edge sources.
    assign irq_clr = irq_take ? (irq_cand & (~irq_cand + NSRC'(1)) & edge_sel_q) : '0;
    assign fiq_clr = fiq_take ? (fiq_cand & (~fiq_cand + NSRC'(1)) & edge_sel_q) : '0;

    always_comb begin
        mask_d     = (CfgWE && CfgAddr == INTC_MASK)   ? CfgWData[NSRC-1:0] : mask_q;
        fiqsel_d   = (CfgWE && CfgAddr == INTC_FIQSEL) ? CfgWData[NSRC-1:0] : fiqsel_q;
        edge_sel_d = (CfgWE && CfgAddr == INTC_EDGE)   ? CfgWData[NSRC-1:0] : edge_sel_q;

        pend_d = pend_q;
        if (CfgWE && CfgAddr == INTC_PENDING) pend_d = pend_d & ~CfgWData[NSRC-1:0];
        pend_d = pend_d & ~(irq_clr | fiq_clr);
        // A new rise applied last so it beats any same-cycle clear.
        pend_d = pend_d | src_rise;
        pend_d = (pend_d & edge_sel_q) | (src_level & ~edge_sel_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q      <= '0;
            fiqsel_q    <= '0;
            edge_sel_q  <= '0;
            pend_q      <= '0;
            irq_id_q    <= '0;
            fiq_id_q    <= '0;
            irq_state_q <= INTC_IDLE;
            fiq_state_q <= INTC_IDLE;
        end else begin
            mask_q      <= mask_d;
            fiqsel_q    <= fiqsel_d;
            edge_sel_q  <= edge_sel_d;
            pend_q      <= pend_d;
            irq_id_q    <= irq_id_d;
            fiq_id_q    <= fiq_id_d;
            irq_state_q <= irq_state_d;
            fiq_state_q <= fiq_state_d;
        end
    end

    always_comb begin
        CfgRData = 32'd0;
        case (CfgAddr)
            INTC_MASK:      CfgRData[NSRC-1:0] = mask_q;
            INTC_FIQSEL:    CfgRData[NSRC-1:0] = fiqsel_q;
            INTC_EDGE:      CfgRData[NSRC-1:0] = edge_sel_q;
            INTC_PENDING:   CfgRData[NSRC-1:0] = pend_q;
            INTC_IRQ_CLAIM: CfgRData[IDW-1:0]  = irq_id_q;
            INTC_FIQ_CLAIM: CfgRData[IDW-1:0]  = fiq_id_q;
            default:        CfgRData = 32'd0;
        endcase
    end

    assign IRQ   = (irq_state_q == INTC_REQ);
    assign FIQ   = (fiq_state_q == INTC_REQ);
    assign IRQId = irq_id_q;
    assign FIQId = fiq_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register table plus hand-written
// latency, priority, level, withdrawal and race sequences.
module tb_interrupt_controller;
    timeunit 1ns;
    timeprecision 100ps;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  IntSrc = '0;
    logic        CfgWE = 1'b0;
    logic [2:0]  CfgAddr = '0;
    logic [31:0] CfgWData = '0;
    logic [31:0] CfgRData;
    logic        IRQAssert = 1'b0;
    logic        FIQAssert = 1'b0;
    logic        IRQ, FIQ;
    logic [2:0]  IRQId, FIQId;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    interrupt_controller #(.NSRC(8), .IDW(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .IntSrc    (IntSrc),
        .CfgWE     (CfgWE),
        .CfgAddr   (CfgAddr),
        .CfgWData  (CfgWData),
        .CfgRData  (CfgRData),
        .IRQAssert (IRQAssert),
        .FIQAssert (FIQAssert),
        .IRQ       (IRQ),
        .FIQ       (FIQ),
        .IRQId     (IRQId),
        .FIQId     (FIQId)
    );

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        CfgAddr = a;
        #0.2;
        check(name, CfgRData, exp);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        CfgWE    = 1'b1;
        CfgAddr  = a;
        CfgWData = d;
        @(negedge clk);
        CfgWE    = 1'b0;
        CfgWData = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        vecs[0] = '{"mask_wr",     3'd0, 32'hFFFF_FF5A, 32'h0000_005A};
        vecs[1] = '{"fiqsel_wr",   3'd1, 32'hDEAD_BEA5, 32'h0000_00A5};
        vecs[2] = '{"edge_wr",     3'd2, 32'h0000_010F, 32'h0000_000F};
        vecs[3] = '{"pend_w1c",    3'd3, 32'h0000_00FF, 32'h0000_0000};
        vecs[4] = '{"reserved",    3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{"irq_claim_ro",3'd4, 32'h0000_00FF, 32'h0000_0000};
        vecs[6] = '{"mask_clr",    3'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{"fiqsel_clr",  3'd1, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{"edge_clr",    3'd2, 32'h0000_0000, 32'h0000_0000};

        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_fiq", {31'd0, FIQ}, 32'd0);
        for (int a = 0; a < 8; a++) chk_reg("rst_reg", 3'(a), 32'd0);

        // Register table
        for (int i = 0; i < 9; i++) begin
            cfg_write(vecs[i].addr, vecs[i].wdata);
            chk_reg(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end

        // 1. Edge IRQ latency, ack, EOI
        cfg_write(3'd2, 32'h01);
        cfg_write(3'd0, 32'h01);
        IntSrc = 8'h01;
        tick(1);
        IntSrc = 8'h00;
        tick(2);
        check("t1_irq_early", {31'd0, IRQ}, 32'd0);
        chk_reg("t1_pend_set", 3'd3, 32'h01);
        tick(1);
        check("t1_irq_lat4", {31'd0, IRQ}, 32'd1);
        IRQAssert = 1'b1;
        tick(1);
        IRQAssert = 1'b0;
        check("t1_irq_ack", {31'd0, IRQ}, 32'd0);
        check("t1_irqid", {29'd0, IRQId}, 32'd0);
        chk_reg("t1_pend_clr", 3'd3, 32'h00);
        cfg_write(3'd6, 32'h1);
        tick(2);
        check("t1_idle", {31'd0, IRQ}, 32'd0);

        // 2. Priority and FIQ routing
        do_reset();
        cfg_write(3'd0, 32'hFF);
        cfg_write(3'd1, 32'h20);
        cfg_write(3'd2, 32'hFF);
        IntSrc = 8'h28;
        tick(4);
        check("t2_irq", {31'd0, IRQ}, 32'd1);
        check("t2_fiq", {31'd0, FIQ}, 32'd1);
        FIQAssert = 1'b1;
        tick(1);
        FIQAssert = 1'b0;
        check("t2_fiqid", {29'd0, FIQId}, 32'd5);
        check("t2_fiq_ack", {31'd0, FIQ}, 32'd0);
        check("t2_irq_hold", {31'd0, IRQ}, 32'd1);
        IRQAssert = 1'b1;
        tick(1);
        IRQAssert = 1'b0;
        check("t2_irqid", {29'd0, IRQId}, 32'd3);
        check("t2_irq_ack", {31'd0, IRQ}, 32'd0);
        chk_reg("t2_pend", 3'd3, 32'h00);
        chk_reg("t2_fiq_claim", 3'd5, 32'd5);
        cfg_write(3'd6, 32'h3);
        tick(2);
        check("t2_irq_done", {31'd0, IRQ}, 32'd0);
        check("t2_fiq_done", {31'd0, FIQ}, 32'd0);
        IntSrc = 8'h00;
        tick(3);

        // 3. Level source re-request
        do_reset();
        cfg_write(3'd0, 32'h04);
        IntSrc = 8'h04;
        tick(4);
        check("t3_irq", {31'd0, IRQ}, 32'd1);
        IRQAssert = 1'b1;
        tick(1);
        IRQAssert = 1'b0;
        check("t3_irqid", {29'd0, IRQId}, 32'd2);
        chk_reg("t3_pend_level", 3'd3, 32'h04);
        cfg_write(3'd6, 32'h1);
        check("t3_idle", {31'd0, IRQ}, 32'd0);
        tick(1);
        check("t3_rereq", {31'd0, IRQ}, 32'd1);
        IRQAssert = 1'b1;
        tick(1);
        IRQAssert = 1'b0;
        IntSrc = 8'h00;
        tick(3);
        chk_reg("t3_pend_drop", 3'd3, 32'h00);
        cfg_write(3'd6, 32'h1);
        tick(2);
        check("t3_no_rereq", {31'd0, IRQ}, 32'd0);

        // 4. Withdrawal by mask, ignored ack in IDLE (IRQId is 2 from above)
        cfg_write(3'd2, 32'h02);
        cfg_write(3'd0, 32'h02);
        IntSrc = 8'h02;
        tick(1);
        IntSrc = 8'h00;
        tick(3);
        check("t4_irq", {31'd0, IRQ}, 32'd1);
        cfg_write(3'd0, 32'h00);
        tick(1);
        check("t4_withdrawn", {31'd0, IRQ}, 32'd0);
        chk_reg("t4_no_claim", 3'd4, 32'd2);
        chk_reg("t4_pend_kept", 3'd3, 32'h02);
        IRQAssert = 1'b1;
        tick(1);
        IRQAssert = 1'b0;
        check("t4_ack_idle", {29'd0, IRQId}, 32'd2);
        check("t4_irq_idle", {31'd0, IRQ}, 32'd0);

        // 5a. W1C racing a new rise on the same bit, then a plain W1C
        IntSrc = 8'h02;
        tick(2);
        cfg_write(3'd3, 32'h02);
        chk_reg("t5_set_wins", 3'd3, 32'h02);
        cfg_write(3'd3, 32'h02);
        chk_reg("t5_w1c", 3'd3, 32'h00);
        IntSrc = 8'h00;

        // 5b. Reset while in SERVICE
        cfg_write(3'd1, 32'h80);
        cfg_write(3'd2, 32'h10);
        cfg_write(3'd0, 32'h10);
        IntSrc = 8'h10;
        tick(1);
        IntSrc = 8'h00;
        tick(3);
        check("t5_irq", {31'd0, IRQ}, 32'd1);
        IRQAssert = 1'b1;
        tick(1);
        IRQAssert = 1'b0;
        check("t5_irqid", {29'd0, IRQId}, 32'd4);
        reset_n = 1'b0;
        #1;
        check("t5_rst_irq", {31'd0, IRQ}, 32'd0);
        check("t5_rst_irqid", {29'd0, IRQId}, 32'd0);
        chk_reg("t5_rst_mask", 3'd0, 32'd0);
        chk_reg("t5_rst_fiqsel", 3'd1, 32'd0);
        chk_reg("t5_rst_edge", 3'd2, 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(3);
        check("t5_post_irq", {31'd0, IRQ}, 32'd0);
        chk_reg("t5_post_pend", 3'd3, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
